dsp_mac_pipeline: RTL and testbench



---
 rtl/dsp_mac_pipeline.sv | 139 +++++++++++++
 tb/tb_dsp_mac_pipeline.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_mac_pipeline.sv
// Fully pipelined multiply-accumulate engine with one operand pair per cycle.
// Supports signed/unsigned operands, accumulate or plain multiply, optional saturation, and output backpressure.
module dsp_mac_pipeline #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int LATENCY    = 3,
  parameter int SATURATE   = 1
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ap_start,
  output logic                  ap_ready,
  output logic                  ap_idle,
  output logic                  ap_done,
  input  logic                  ap_continue,
  input  logic                  mode_signed,
  input  logic                  acc_en,
  input  logic                  acc_clr,
  input  logic [DATA_WIDTH-1:0] x,
  input  logic [DATA_WIDTH-1:0] y,
  output logic [ACC_WIDTH-1:0]  result,
  output logic                  overflow
);

  logic                  stall;
  logic [LATENCY:1]      vld;
  logic [DATA_WIDTH-1:0] s1_x, s1_y;
  logic                  s1_sgn, s1_en, s1_clr;

  logic signed [DATA_WIDTH:0]  xs, ys;
  logic signed [ACC_WIDTH-1:0] xw, yw;
  logic [ACC_WIDTH-1:0]        prod1;

  logic [ACC_WIDTH-1:0] ls_prod;
  logic                 ls_sgn, ls_en, ls_clr;

  logic [ACC_WIDTH-1:0] acc, acc_next, base;
  logic [ACC_WIDTH:0]   sum;
  logic                 ovf, ovf_next, add_ovf;

  assign stall    = vld[LATENCY] & ~ap_continue;
  assign ap_ready = ~stall;
  assign ap_done  = vld[LATENCY];
  assign ap_idle  = ~ap_start & ~(|vld);
  assign result   = acc;
  assign overflow = ovf;

  // Operands widened by one bit so the same multiplier yields both signed and unsigned products,
  // already extended to the accumulator width.
  always_comb begin
    xs    = {s1_sgn & s1_x[DATA_WIDTH-1], s1_x};
    ys    = {s1_sgn & s1_y[DATA_WIDTH-1], s1_y};
    xw    = ACC_WIDTH'(xs);
    yw    = ACC_WIDTH'(ys);
    prod1 = xw * yw;
  end

  generate
    if (LATENCY == 2) begin : g_direct
      assign ls_prod = prod1;
      assign ls_sgn  = s1_sgn;
      assign ls_en   = s1_en;
      assign ls_clr  = s1_clr;
    end else begin : g_delay
      logic [ACC_WIDTH-1:0] d_prod [2:LATENCY-1];
      logic [2:0]           d_mode [2:LATENCY-1];

      always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
          for (int unsigned k = 2; k < LATENCY; k++) begin
            d_prod[k] <= '0;
            d_mode[k] <= '0;
          end
        end else if (!stall) begin
          d_prod[2] <= prod1;
          d_mode[2] <= {s1_sgn, s1_en, s1_clr};
          for (int unsigned k = 3; k < LATENCY; k++) begin
            d_prod[k] <= d_prod[k-1];
            d_mode[k] <= d_mode[k-1];
          end
        end
      end

      assign ls_prod                 = d_prod[LATENCY-1];
      assign {ls_sgn, ls_en, ls_clr} = d_mode[LATENCY-1];
    end
  endgenerate

  always_comb begin
    base    = ls_clr ? '0 : acc;
    sum     = {1'b0, base} + {1'b0, ls_prod};
    add_ovf = 1'b0;
    if (ls_sgn)
      add_ovf = (base[ACC_WIDTH-1] == ls_prod[ACC_WIDTH-1]) &&
                (sum[ACC_WIDTH-1] != base[ACC_WIDTH-1]);
    else
      add_ovf = sum[ACC_WIDTH];
    acc_next = sum[ACC_WIDTH-1:0];
    // Signed overflow can only occur toward the product's sign, so it picks the clamp rail.
    if (add_ovf && (SATURATE != 0)) begin
      if (!ls_sgn)
        acc_next = '1;
      else if (ls_prod[ACC_WIDTH-1])
        acc_next = {1'b1, {(ACC_WIDTH-1){1'b0}}};
      else
        acc_next = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
    ovf_next = add_ovf | (ovf & ~ls_clr);
    if (!ls_en) begin
      acc_next = ls_prod;
      ovf_next = 1'b0;
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      vld    <= '0;
      s1_x   <= '0;
      s1_y   <= '0;
      s1_sgn <= 1'b0;
      s1_en  <= 1'b0;
      s1_clr <= 1'b0;
      acc    <= '0;
      ovf    <= 1'b0;
    end else if (!stall) begin
      vld    <= {vld[LATENCY-1:1], ap_start};
      s1_x   <= x;
      s1_y   <= y;
      s1_sgn <= mode_signed;
      s1_en  <= acc_en;
      s1_clr <= acc_clr;
      if (vld[LATENCY-1]) begin
        acc <= acc_next;
        ovf <= ovf_next;
      end
    end
  end

endmodule

// File: tb/tb_dsp_mac_pipeline.sv
// Self-checking bench for dsp_mac_pipeline: directed spec scenarios plus randomized traffic
// checked against an arithmetic reference model.
module tb_dsp_mac_pipeline;
  localparam int DW  = 16;
  localparam int AW  = 40;
  localparam int LAT = 3;
  localparam longint SMAX = (64'sd1 <<< 39) - 1;
  localparam longint SMIN = -(64'sd1 <<< 39);
  localparam longint UMAX = (64'sd1 <<< 40) - 1;

  logic          ap_clk = 1'b0;
  logic          ap_rst, ap_start, ap_continue, mode_signed, acc_en, acc_clr;
  logic [DW-1:0] x, y;
  logic          ap_ready, ap_idle, ap_done, overflow;
  logic [AW-1:0] result;

  dsp_mac_pipeline #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .LATENCY(LAT), .SATURATE(1)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_idle(ap_idle), .ap_done(ap_done), .ap_continue(ap_continue),
    .mode_signed(mode_signed), .acc_en(acc_en), .acc_clr(acc_clr),
    .x(x), .y(y), .result(result), .overflow(overflow)
  );

  always #5 ap_clk = ~ap_clk;

  int n_run  = 0;
  int n_fail = 0;

  logic [DW-1:0] sx [600];
  logic [DW-1:0] sy [600];
  bit            ssg[600], sen[600], scl[600];
  logic [AW-1:0] exp_r[600];
  bit            exp_o[600];

  logic [AW-1:0] res_q[$];
  bit            ovf_q[$];
  int            hs_cyc[$], acc_cyc[$];
  bit            stall_rdy[$];
  logic [AW-1:0] stall_res[$];
  int            extra_hs;

  logic [AW-1:0] m_acc;
  bit            m_ovf;

  task automatic tick;
    @(posedge ap_clk);
    #1;
  endtask

  task automatic load(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input bit sg, input bit en, input bit cl);
    sx[i] = a; sy[i] = b; ssg[i] = sg; sen[i] = en; scl[i] = cl;
  endtask

  // Reference: true-integer arithmetic, range-checked against the accumulator width.
  function automatic void model_step(input bit sg, input bit en, input bit cl,
                                     input logic [DW-1:0] a, input logic [DW-1:0] b);
    longint p, bs, s;
    bit o;
    if (sg) p = longint'($signed(a)) * longint'($signed(b));
    else    p = longint'(a) * longint'(b);
    if (!en) begin
      m_acc = 40'(p);
      m_ovf = 1'b0;
      return;
    end
    o = 1'b0;
    if (sg) begin
      bs = cl ? 64'sd0 : longint'($signed(m_acc));
      s  = bs + p;
      if (s > SMAX)      begin o = 1'b1; s = SMAX; end
      else if (s < SMIN) begin o = 1'b1; s = SMIN; end
    end else begin
      bs = cl ? 64'sd0 : longint'({24'd0, m_acc});
      s  = bs + p;
      if (s > UMAX) begin o = 1'b1; s = UMAX; end
    end
    m_acc = 40'(s);
    m_ovf = (cl ? 1'b0 : m_ovf) | o;
  endfunction

  task automatic compute_expected(input int n);
    for (int i = 0; i < n; i++) begin
      model_step(ssg[i], sen[i], scl[i], sx[i], sy[i]);
      exp_r[i] = m_acc;
      exp_o[i] = m_ovf;
    end
  endtask

  // Drives samples 0..n-1 in order and records every done/continue handshake.
  task automatic run_stream(input int n, input int stall_cycles, input bit rnd);
    int sent = 0;
    int cyc = 0;
    int first_done = -1;
    int budget = n * 8 + 40;
    bit hold;
    res_q.delete(); ovf_q.delete(); hs_cyc.delete(); acc_cyc.delete();
    stall_rdy.delete(); stall_res.delete();
    while (res_q.size() < n && cyc < budget) begin
      if (sent < n && (!rnd || $urandom_range(0, 3) != 0)) begin
        ap_start = 1'b1; x = sx[sent]; y = sy[sent];
        mode_signed = ssg[sent]; acc_en = sen[sent]; acc_clr = scl[sent];
      end else begin
        ap_start = 1'b0;
      end
      if (ap_done && first_done < 0) first_done = cyc;
      hold = (first_done >= 0) && (cyc < first_done + stall_cycles);
      if (hold)     ap_continue = 1'b0;
      else if (rnd) ap_continue = ($urandom_range(0, 2) != 0);
      else          ap_continue = 1'b1;
      #1;
      if (hold) begin
        stall_rdy.push_back(ap_ready);
        stall_res.push_back(result);
      end
      if (ap_done && ap_continue) begin
        res_q.push_back(result); ovf_q.push_back(overflow); hs_cyc.push_back(cyc);
      end
      if (ap_start && ap_ready) begin
        acc_cyc.push_back(cyc);
        sent++;
      end
      tick;
      cyc++;
    end
    ap_start = 1'b0;
    ap_continue = 1'b1;
    extra_hs = 0;
    for (int k = 0; k < 6; k++) begin
      if (ap_done) extra_hs++;
      tick;
    end
  endtask

  task automatic test_reset;
    ap_rst = 1'b1; ap_start = 1'b0; ap_continue = 1'b1;
    mode_signed = 1'b0; acc_en = 1'b0; acc_clr = 1'b0; x = '0; y = '0;
    tick; tick;
    n_run++; if (ap_done !== 1'b0)  begin n_fail++; $display("FAIL rst_done: got %b expected 0", ap_done); end
    n_run++; if (result !== '0)     begin n_fail++; $display("FAIL rst_result: got %h expected 0", result); end
    n_run++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_ovf: got %b expected 0", overflow); end
    n_run++; if (ap_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b expected 1", ap_ready); end
    n_run++; if (ap_idle !== 1'b1)  begin n_fail++; $display("FAIL rst_idle: got %b expected 1", ap_idle); end
    ap_rst = 1'b0;
    m_acc = '0; m_ovf = 1'b0;
    tick;
  endtask

  task automatic test_signed_mult;
    load(0, 16'hFFFD, 16'd7, 1, 0, 0);
    run_stream(1, 0, 0);
    n_run++;
    if (res_q.size() != 1) begin
      n_fail++; $display("FAIL sm_count: got %0d handshakes expected 1", res_q.size());
    end else begin
      n_run++; if (hs_cyc[0] - acc_cyc[0] != LAT) begin n_fail++; $display("FAIL sm_latency: got %0d expected %0d", hs_cyc[0] - acc_cyc[0], LAT); end
      n_run++; if (res_q[0] !== 40'hFF_FFFF_FFEB) begin n_fail++; $display("FAIL sm_result: got %h expected ffffffffeb", res_q[0]); end
      n_run++; if (ovf_q[0] !== 1'b0) begin n_fail++; $display("FAIL sm_ovf: got %b expected 0", ovf_q[0]); end
    end
    n_run++; if (ap_idle !== 1'b1) begin n_fail++; $display("FAIL sm_idle_after: got %b expected 1", ap_idle); end
    n_run++; if (result !== 40'hFF_FFFF_FFEB) begin n_fail++; $display("FAIL sm_result_hold: got %h expected ffffffffeb", result); end
  endtask

  task automatic test_unsigned_vs_signed;
    load(0, 16'hFFFF, 16'd2, 0, 0, 0);
    load(1, 16'hFFFF, 16'd2, 1, 0, 0);
    run_stream(2, 0, 0);
    n_run++;
    if (res_q.size() != 2) begin
      n_fail++; $display("FAIL uvs_count: got %0d handshakes expected 2", res_q.size());
    end else begin
      n_run++; if (res_q[0] !== 40'h00_0001_FFFE) begin n_fail++; $display("FAIL uvs_unsigned: got %h expected 000001fffe", res_q[0]); end
      n_run++; if (res_q[1] !== 40'hFF_FFFF_FFFE) begin n_fail++; $display("FAIL uvs_signed: got %h expected fffffffffe", res_q[1]); end
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++) load(i, 16'd1000, 16'd1000, 0, 1, i == 0);
    run_stream(4, 0, 0);
    n_run++;
    if (res_q.size() != 4) begin
      n_fail++; $display("FAIL b2b_count: got %0d handshakes expected 4", res_q.size());
    end else begin
      n_run++; if (hs_cyc[3] - hs_cyc[0] != 3) begin n_fail++; $display("FAIL b2b_consecutive: got span %0d expected 3", hs_cyc[3] - hs_cyc[0]); end
      for (int i = 0; i < 4; i++) begin
        n_run++;
        if (res_q[i] !== 40'(1000000 * (i + 1))) begin
          n_fail++; $display("FAIL b2b_result[%0d]: got %0d expected %0d", i, res_q[i], 1000000 * (i + 1));
        end
      end
    end
    n_run++; if (extra_hs != 0) begin n_fail++; $display("FAIL b2b_extra: got %0d extra done cycles expected 0", extra_hs); end
    n_run++; if (result !== 40'd4000000) begin n_fail++; $display("FAIL b2b_hold: got %0d expected 4000000", result); end
    n_run++; if (ap_done !== 1'b0) begin n_fail++; $display("FAIL b2b_done_drop: got %b expected 0", ap_done); end
  endtask

  task automatic test_backpressure;
    for (int i = 0; i < 4; i++) load(i, 16'd1000, 16'd1000, 0, 1, i == 0);
    run_stream(4, 2, 0);
    n_run++;
    if (res_q.size() != 4) begin
      n_fail++; $display("FAIL bp_count: got %0d handshakes expected 4", res_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_run++;
        if (res_q[i] !== 40'(1000000 * (i + 1))) begin
          n_fail++; $display("FAIL bp_result[%0d]: got %0d expected %0d", i, res_q[i], 1000000 * (i + 1));
        end
      end
    end
    n_run++; if (extra_hs != 0) begin n_fail++; $display("FAIL bp_extra: got %0d extra done cycles expected 0", extra_hs); end
    n_run++;
    if (stall_rdy.size() != 2) begin
      n_fail++; $display("FAIL bp_stall_cycles: got %0d expected 2", stall_rdy.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        n_run++; if (stall_rdy[i] !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b expected 0", i, stall_rdy[i]); end
        n_run++; if (stall_res[i] !== 40'd1000000) begin n_fail++; $display("FAIL bp_hold[%0d]: got %0d expected 1000000", i, stall_res[i]); end
      end
    end
  endtask

  task automatic test_saturation;
    int bad = 0;
    for (int i = 0; i < 512; i++) load(i, 16'h8000, 16'h8000, 1, 1, i == 0);
    load(512, 16'd1, 16'd1, 1, 1, 1);
    compute_expected(513);
    run_stream(513, 0, 0);
    n_run++;
    if (res_q.size() != 513) begin
      n_fail++; $display("FAIL sat_count: got %0d handshakes expected 513", res_q.size());
    end else begin
      n_run++; if (res_q[510] !== 40'h7F_C000_0000) begin n_fail++; $display("FAIL sat_511_result: got %h expected 7fc0000000", res_q[510]); end
      n_run++; if (ovf_q[510] !== 1'b0) begin n_fail++; $display("FAIL sat_511_ovf: got %b expected 0", ovf_q[510]); end
      n_run++; if (res_q[511] !== 40'h7F_FFFF_FFFF) begin n_fail++; $display("FAIL sat_512_result: got %h expected 7fffffffff", res_q[511]); end
      n_run++; if (ovf_q[511] !== 1'b1) begin n_fail++; $display("FAIL sat_512_ovf: got %b expected 1", ovf_q[511]); end
      n_run++; if (res_q[512] !== 40'd1) begin n_fail++; $display("FAIL sat_clr_result: got %h expected 1", res_q[512]); end
      n_run++; if (ovf_q[512] !== 1'b0) begin n_fail++; $display("FAIL sat_clr_ovf: got %b expected 0", ovf_q[512]); end
      for (int i = 0; i < 513; i++)
        if (res_q[i] !== exp_r[i] || ovf_q[i] !== exp_o[i]) bad++;
      n_run++; if (bad != 0) begin n_fail++; $display("FAIL sat_model: got %0d differing samples expected 0", bad); end
    end
  endtask

  task automatic test_reset_midflight;
    ap_continue = 1'b1; mode_signed = 1'b0; acc_en = 1'b0; acc_clr = 1'b0;
    ap_start = 1'b1; x = 16'd5; y = 16'd7;
    tick;
    x = 16'd9; y = 16'd9;
    tick;
    ap_start = 1'b0;
    tick;
    n_run++; if (ap_done !== 1'b1) begin n_fail++; $display("FAIL rmf_pre_done: got %b expected 1", ap_done); end
    n_run++; if (result !== 40'd35) begin n_fail++; $display("FAIL rmf_pre_result: got %0d expected 35", result); end
    ap_rst = 1'b1;
    #1;
    n_run++; if (ap_done !== 1'b0)  begin n_fail++; $display("FAIL rmf_done: got %b expected 0", ap_done); end
    n_run++; if (result !== '0)     begin n_fail++; $display("FAIL rmf_result: got %h expected 0", result); end
    n_run++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rmf_ovf: got %b expected 0", overflow); end
    n_run++; if (ap_idle !== 1'b1)  begin n_fail++; $display("FAIL rmf_idle: got %b expected 1", ap_idle); end
    tick;
    ap_rst = 1'b0;
    m_acc = '0; m_ovf = 1'b0;
    load(0, 16'd2, 16'd3, 0, 1, 0);
    run_stream(1, 0, 0);
    n_run++;
    if (res_q.size() != 1) begin
      n_fail++; $display("FAIL rmf_after_count: got %0d handshakes expected 1", res_q.size());
    end else begin
      n_run++; if (res_q[0] !== 40'd6) begin n_fail++; $display("FAIL rmf_after_result: got %0d expected 6", res_q[0]); end
    end
  endtask

  task automatic test_random;
    int n = 200;
    for (int i = 0; i < n; i++) begin
      load(i, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
           (i == 0) || ($urandom_range(0, 15) != 0), (i == 0) || ($urandom_range(0, 63) == 0));
    end
    compute_expected(n);
    run_stream(n, 0, 1);
    n_run++;
    if (res_q.size() != n) begin
      n_fail++; $display("FAIL rnd_count: got %0d handshakes expected %0d", res_q.size(), n);
    end else begin
      for (int i = 0; i < n; i++) begin
        n_run++;
        if (res_q[i] !== exp_r[i]) begin
          n_fail++; $display("FAIL rnd_result[%0d]: got %h expected %h", i, res_q[i], exp_r[i]);
        end
        n_run++;
        if (ovf_q[i] !== exp_o[i]) begin
          n_fail++; $display("FAIL rnd_ovf[%0d]: got %b expected %b", i, ovf_q[i], exp_o[i]);
        end
      end
    end
    n_run++; if (extra_hs != 0) begin n_fail++; $display("FAIL rnd_extra: got %0d extra done cycles expected 0", extra_hs); end
  endtask

  initial begin
    test_reset;
    test_signed_mult;
    test_unsigned_vs_signed;
    test_back_to_back;
    test_backpressure;
    test_saturation;
    test_reset_midflight;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
